// File: rtl/dm_pkg.sv
// Shared debug-module package: DMI request/response types and arbiter constants.
package dm;

    typedef enum logic [1:0] {
        DTM_NOP   = 2'h0,
        DTM_READ  = 2'h1,
        DTM_WRITE = 2'h2
    } dtm_op_e;

    typedef struct packed {
        logic [6:0]  addr;
        dtm_op_e     op;
        logic [31:0] data;
    } dmi_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_resp_t;

    // Width of the orphan-response drop counter.
    localparam int unsigned DmiArbCntWidth = 8;

    // Port index width; a single port still needs a 1-bit index.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_v3.sv
// Small synchronous FIFO with flush; used as the in-order routing FIFO.
// Push while full and pop while empty are ignored.
module fifo_v3 #(
    parameter int unsigned DATA_WIDTH = 1,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    output logic                  full_o,
    output logic                  empty_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  pop_i
);

    localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW  = $clog2(DEPTH + 1);
    localparam logic [AddrW-1:0] LastPtr = AddrW'(DEPTH - 1);
    localparam logic [CntW-1:0]  FullCnt = CntW'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AddrW-1:0]      r_wr_ptr;
    logic [AddrW-1:0]      r_rd_ptr;
    logic [CntW-1:0]       r_cnt;
    logic                  w_push;
    logic                  w_pop;

    assign full_o  = (r_cnt == FullCnt);
    assign empty_o = (r_cnt == '0);
    assign w_push  = push_i & ~full_o & ~flush_i;
    assign w_pop   = pop_i & ~empty_o & ~flush_i;
    assign data_o  = r_mem[r_rd_ptr];

    // Pointer and occupancy bookkeeping; flush empties the FIFO.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == LastPtr) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == LastPtr) ? '0 : r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (w_pop && !w_push) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // Storage array; contents are don't-care while the entry is not occupied.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

endmodule

// File: rtl/dmi_arbiter.sv
// Round-robin arbiter merging NrPorts DMI channels onto one downstream port.
// Each accepted request's port index goes into an in-order routing FIFO so
// the matching downstream response is steered back to its originator.
// Optional macro DMI_ARBITER_DROP_CNT_EN enables the orphan-response counter.
//
// Handshakes: a transfer happens on a clock edge where valid and ready are
// both 1; a source holding valid keeps its payload stable until that edge.
// Request and response data paths are purely combinational.
module dmi_arbiter
    import dm::*;
#(
    parameter int unsigned NrPorts        = 2,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      clear_i,
    input  dmi_req_t                  up_req_i        [NrPorts],
    input  logic [NrPorts-1:0]        up_req_valid_i,
    output logic [NrPorts-1:0]        up_req_ready_o,
    output dmi_resp_t                 up_resp_o       [NrPorts],
    output logic [NrPorts-1:0]        up_resp_valid_o,
    input  logic [NrPorts-1:0]        up_resp_ready_i,
    output dmi_req_t                  dn_req_o,
    output logic                      dn_req_valid_o,
    input  logic                      dn_req_ready_i,
    input  dmi_resp_t                 dn_resp_i,
    input  logic                      dn_resp_valid_i,
    output logic                      dn_resp_ready_o,
    output logic [DmiArbCntWidth-1:0] drop_cnt_o
);

    localparam int unsigned IdxW = idx_width(NrPorts);
    localparam logic [IdxW-1:0] LastPort = IdxW'(NrPorts - 1);

    logic [IdxW-1:0] r_rr;
    logic            r_lock;
    logic [IdxW-1:0] r_lock_idx;

    logic [IdxW-1:0] w_scan_idx;
    logic            w_scan_found;
    logic [IdxW-1:0] w_cand;
    logic [IdxW-1:0] w_grant_idx;
    logic            w_grant_vld;
    logic            w_req_hs;
    logic            w_fifo_full;
    logic            w_fifo_empty;
    logic [IdxW-1:0] w_head;
    logic            w_pop;

    // First valid port at or after the round-robin pointer, wrapping.
    always_comb begin
        w_scan_found = 1'b0;
        w_scan_idx   = '0;
        w_cand       = '0;
        for (int unsigned i = 0; i < NrPorts; i++) begin
            w_cand = IdxW'((32'(r_rr) + i) % NrPorts);
            if (!w_scan_found && up_req_valid_i[w_cand]) begin
                w_scan_found = 1'b1;
                w_scan_idx   = w_cand;
            end
        end
    end

    // Grant selection: a stalled request keeps its port; full FIFO or clear
    // suppresses the downstream request entirely.
    always_comb begin
        w_grant_idx    = r_lock ? r_lock_idx : w_scan_idx;
        w_grant_vld    = r_lock ? up_req_valid_i[r_lock_idx] : w_scan_found;
        dn_req_valid_o = w_grant_vld & ~w_fifo_full & ~clear_i;
        dn_req_o       = up_req_i[w_grant_idx];
        up_req_ready_o = '0;
        if (dn_req_valid_o) begin
            up_req_ready_o[w_grant_idx] = dn_req_ready_i;
        end
        w_req_hs       = dn_req_valid_o & dn_req_ready_i;
    end

    // Round-robin pointer advance and stall lock.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr       <= '0;
            r_lock     <= 1'b0;
            r_lock_idx <= '0;
        end else if (clear_i) begin
            r_rr       <= '0;
            r_lock     <= 1'b0;
            r_lock_idx <= '0;
        end else begin
            if (w_req_hs) begin
                r_rr <= (w_grant_idx == LastPort) ? '0 : w_grant_idx + 1'b1;
            end
            r_lock <= dn_req_valid_o & ~dn_req_ready_i;
            if (dn_req_valid_o && !dn_req_ready_i) begin
                r_lock_idx <= w_grant_idx;
            end
        end
    end

    // Routing FIFO holding the issuing port of each outstanding request.
    fifo_v3 #(
        .DATA_WIDTH (IdxW),
        .DEPTH      (MaxOutstanding)
    ) u_route_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (clear_i),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty),
        .data_i  (w_grant_idx),
        .push_i  (w_req_hs),
        .data_o  (w_head),
        .pop_i   (w_pop)
    );

    assign up_resp_o = '{default: dn_resp_i};

    // Response steering to the FIFO head; with nothing outstanding (or while
    // clearing) downstream responses are accepted and discarded.
    always_comb begin
        up_resp_valid_o = '0;
        dn_resp_ready_o = 1'b1;
        w_pop           = 1'b0;
        if (!clear_i && !w_fifo_empty) begin
            up_resp_valid_o[w_head] = dn_resp_valid_i;
            dn_resp_ready_o         = up_resp_ready_i[w_head];
            w_pop                   = dn_resp_valid_i & up_resp_ready_i[w_head];
        end
    end

`ifdef DMI_ARBITER_DROP_CNT_EN
    logic                      w_orphan;
    logic [DmiArbCntWidth-1:0] r_drop_cnt;

    assign w_orphan   = dn_resp_valid_i & w_fifo_empty & ~clear_i;
    assign drop_cnt_o = r_drop_cnt;

    // Saturating count of responses that arrived with nothing outstanding.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_drop_cnt <= '0;
        end else if (clear_i) begin
            r_drop_cnt <= '0;
        end else if (w_orphan && (r_drop_cnt != '1)) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end
`else
    assign drop_cnt_o = '0;
`endif

endmodule

// File: tb/tb_dmi_arbiter.sv
// Randomized bench for dmi_arbiter against a queue-based reference model.
module tb_dmi_arbiter;
  import dm::*;

  localparam int NP = 2;
  localparam int MO = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  logic            clear_i;
  dmi_req_t        up_req_i [NP];
  logic [NP-1:0]   up_req_valid_i;
  logic [NP-1:0]   up_req_ready_o;
  dmi_resp_t       up_resp_o [NP];
  logic [NP-1:0]   up_resp_valid_o;
  logic [NP-1:0]   up_resp_ready_i;
  dmi_req_t        dn_req_o;
  logic            dn_req_valid_o;
  logic            dn_req_ready_i;
  dmi_resp_t       dn_resp_i;
  logic            dn_resp_valid_i;
  logic            dn_resp_ready_o;
  logic [7:0]      drop_cnt_o;

  dmi_arbiter #(.NrPorts(NP), .MaxOutstanding(MO)) u_dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .clear_i         (clear_i),
    .up_req_i        (up_req_i),
    .up_req_valid_i  (up_req_valid_i),
    .up_req_ready_o  (up_req_ready_o),
    .up_resp_o       (up_resp_o),
    .up_resp_valid_o (up_resp_valid_o),
    .up_resp_ready_i (up_resp_ready_i),
    .dn_req_o        (dn_req_o),
    .dn_req_valid_o  (dn_req_valid_o),
    .dn_req_ready_i  (dn_req_ready_i),
    .dn_resp_i       (dn_resp_i),
    .dn_resp_valid_i (dn_resp_valid_i),
    .dn_resp_ready_o (dn_resp_ready_o),
    .drop_cnt_o      (drop_cnt_o)
  );

  // ---------------- scoreboard / model state ----------------
  int n_chk = 0;
  int n_pass = 0;
  logic [7:0] exp_q[$];   // issuing port of each outstanding request, oldest first
  int m_rr = 0;           // port that has first claim next
  int m_held = -1;        // port whose request is stalled downstream, -1 if none
  int m_drop = 0;         // orphan responses seen since reset/clear
  int m_acc = -1;         // port whose request was accepted this cycle

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  function automatic int exp_drop();
`ifdef DMI_ARBITER_DROP_CNT_EN
    return m_drop;
`else
    return 0;
`endif
  endfunction

  // Compare outputs for the current inputs, then advance the model one edge.
  task automatic step();
    int g = 0;
    int h = 0;
    bit found = 0;
    bit full;
    bit req_v;
    bit pop = 0;
    bit orphan = 0;
    logic [NP-1:0] e_rdy = '0;
    logic [NP-1:0] e_rvld = '0;
    bit e_drdy = 1;
    full = (exp_q.size() == MO);
    if (m_held >= 0) begin
      found = 1;
      g = m_held;
    end else begin
      for (int k = 0; k < NP; k++) begin
        int p;
        p = (m_rr + k) % NP;
        if (!found && up_req_valid_i[p]) begin
          found = 1;
          g = p;
        end
      end
    end
    req_v = !clear_i && found && !full;
    if (req_v && dn_req_ready_i) e_rdy[g] = 1'b1;
    if (!clear_i) begin
      if (exp_q.size() > 0) begin
        h = int'(exp_q[0]);
        e_rvld[h] = dn_resp_valid_i;
        e_drdy = up_resp_ready_i[h];
        pop = dn_resp_valid_i && up_resp_ready_i[h];
      end else begin
        orphan = dn_resp_valid_i;
      end
    end
    check("dn_req_valid", 64'(dn_req_valid_o), 64'(req_v));
    check("up_req_ready", 64'(up_req_ready_o), 64'(e_rdy));
    check("up_resp_valid", 64'(up_resp_valid_o), 64'(e_rvld));
    check("dn_resp_ready", 64'(dn_resp_ready_o), 64'(e_drdy));
    check("drop_cnt", 64'(drop_cnt_o), 64'(exp_drop()));
    if (req_v) check("dn_req_data", 64'(dn_req_o), 64'(up_req_i[g]));
    if (e_rvld != '0) check("up_resp_data", 64'(up_resp_o[h]), 64'(dn_resp_i));
    m_acc = -1;
    if (clear_i) begin
      exp_q.delete();
      m_rr = 0;
      m_held = -1;
      m_drop = 0;
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (req_v && dn_req_ready_i) begin
        exp_q.push_back(8'(g));
        m_rr = (g + 1) % NP;
        m_acc = g;
      end
      m_held = (req_v && !dn_req_ready_i) ? g : -1;
      if (orphan && m_drop < 255) m_drop++;
    end
  endtask

  // ---------------- driver ----------------
  function automatic dmi_req_t rand_req();
    dmi_req_t r;
    r.addr = 7'($urandom_range(0, 127));
    r.op   = dtm_op_e'(2'($urandom_range(0, 2)));
    r.data = $urandom;
    return r;
  endfunction

  // Pending upstream requests stay valid until accepted; new ones appear randomly.
  task automatic drive(input int p_new, input int p_dnrdy, input int p_resp,
                       input int p_clr, input int p_rrdy);
    for (int p = 0; p < NP; p++) begin
      if (m_acc == p) up_req_valid_i[p] = 1'b0;
      if (!up_req_valid_i[p] && $urandom_range(0, 99) < p_new) begin
        up_req_valid_i[p] = 1'b1;
        up_req_i[p] = rand_req();
      end
      up_resp_ready_i[p] = ($urandom_range(0, 99) < p_rrdy);
    end
    dn_req_ready_i  = ($urandom_range(0, 99) < p_dnrdy);
    dn_resp_valid_i = ($urandom_range(0, 99) < p_resp);
    dn_resp_i.data  = $urandom;
    dn_resp_i.resp  = 2'($urandom_range(0, 3));
    clear_i         = ($urandom_range(0, 99) < p_clr);
  endtask

  task automatic cycles(input int n, input int p_new, input int p_dnrdy, input int p_resp,
                        input int p_clr, input int p_rrdy);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      step();
      @(posedge clk);
      #1;
      drive(p_new, p_dnrdy, p_resp, p_clr, p_rrdy);
    end
  endtask

  task automatic idle_inputs();
    clear_i = 1'b0;
    up_req_valid_i = '0;
    up_resp_ready_i = '0;
    dn_req_ready_i = 1'b0;
    dn_resp_valid_i = 1'b0;
    dn_resp_i = '0;
    m_acc = -1;
    for (int p = 0; p < NP; p++) up_req_i[p] = '0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    idle_inputs();
    #23;
    rst_ni = 1'b1;
    cycles(4, 0, 0, 0, 0, 100);        // idle after reset
    cycles(300, 100, 100, 100, 0, 100); // saturated: alternating grants
    cycles(400, 60, 30, 40, 0, 80);     // stalls, locks, full FIFO
    cycles(400, 70, 60, 30, 4, 70);     // clears mixed in, orphans
    cycles(310, 0, 0, 100, 0, 100);     // drain then long orphan run
    cycles(50, 70, 50, 40, 0, 80);      // traffic before reset

    // Asynchronous reset away from the clock edge, mid-traffic.
    @(posedge clk);
    #3;
    idle_inputs();
    dn_resp_valid_i = 1'b1;
    rst_ni = 1'b0;
    #1;
    exp_q.delete();
    m_rr = 0;
    m_held = -1;
    m_drop = 0;
    check("rst_drop_cnt", 64'(drop_cnt_o), 64'd0);
    check("rst_dn_req_valid", 64'(dn_req_valid_o), 64'd0);
    check("rst_up_resp_valid", 64'(up_resp_valid_o), 64'd0);
    check("rst_dn_resp_ready", 64'(dn_resp_ready_o), 64'd1);
    dn_resp_valid_i = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    cycles(200, 60, 60, 50, 2, 80);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
